// File: rtl/hex_entry_reg_pkg.sv
// Shared constants for the hex entry path and the seven-segment display driver.
// Also holds the button map and the action priority encoder.
package hex_entry_reg_pkg;

    localparam int NDIG_DEF      = 8;
    localparam int NIB_W         = 4;
    localparam int DB_CYCLES_DEF = 500000;
    localparam int NUM_BTN       = 3;

    typedef enum logic [1:0] {
        BTN_LOAD  = 2'd0,
        BTN_BACK  = 2'd1,
        BTN_CLEAR = 2'd2
    } btn_e;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_CLEAR,
        ACT_LOAD,
        ACT_BACK
    } act_e;

    // Exactly one action per cycle: clear beats load, and load beats back.
    function automatic act_e pick_action(input logic [NUM_BTN-1:0] press);
        act_e a;
        a = ACT_NONE;
        if (press[BTN_CLEAR])     a = ACT_CLEAR;
        else if (press[BTN_LOAD]) a = ACT_LOAD;
        else if (press[BTN_BACK]) a = ACT_BACK;
        return a;
    endfunction

endpackage

// File: rtl/hex_entry_reg_button_debounce.sv
// Synchronizes, debounces and rising-edge-detects one raw push-button.
// level is the debounced state; press is a one-cycle strobe on the accepted rise.
module button_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic          s1, s2;
    logic          stable, stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_q <= stable;
            // Any sample that agrees with the accepted level restarts the count.
            if (s2 != stable) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = stable;
    assign press = stable & ~stable_q;

endmodule

// File: rtl/hex_entry_reg.sv
// Hex digit entry register: debounced buttons shift switch nibbles in or out
// of a registered value that feeds the display driver directly.
module hex_entry_reg
    import hex_entry_reg_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int NDIG      = NDIG_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NIB_W-1:0]             sw,
    input  logic                         btn_load,
    input  logic                         btn_back,
    input  logic                         btn_clear,
    output logic [NIB_W*NDIG-1:0]        value,
    output logic [$clog2(NDIG+1)-1:0]    digits,
    output logic                         full
);

    localparam int VW = NIB_W * NDIG;
    localparam int DW = $clog2(NDIG + 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] unused_level;
    logic [NUM_BTN-1:0] press;

    always_comb begin
        raw            = '0;
        raw[BTN_LOAD]  = btn_load;
        raw[BTN_BACK]  = btn_back;
        raw[BTN_CLEAR] = btn_clear;
    end

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
        .clock (clock),
        .reset (reset),
        .raw   (raw),
        .level (unused_level),
        .press (press)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            value  <= '0;
            digits <= '0;
            full   <= 1'b0;
        end else begin
            case (pick_action(press))
                ACT_CLEAR: begin
                    value  <= '0;
                    digits <= '0;
                    full   <= 1'b0;
                end
                // A load while full is dropped so no entered digit is lost.
                ACT_LOAD: if (!full) begin
                    value  <= {value[VW-NIB_W-1:0], sw};
                    digits <= digits + 1'b1;
                    full   <= (digits == DW'(NDIG - 1));
                end
                ACT_BACK: if (digits != '0) begin
                    value  <= {{NIB_W{1'b0}}, value[VW-1:NIB_W]};
                    digits <= digits - 1'b1;
                    full   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_entry_reg.sv
// Randomized self-checking bench for hex_entry_reg; the reference model keeps
// the entered digits as a queue and rebuilds the expected value from it.
module tb_hex_entry_reg;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  sw;
    logic        btn_load, btn_back, btn_clear;
    logic [31:0] value;
    logic [3:0]  digits;
    logic        full;

    int n_chk = 0;
    int n_err = 0;
    bit [3:0] mq[$];

    always #5 clock = ~clock;

    hex_entry_reg #(.DB_CYCLES(DB), .NDIG(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_back  (btn_back),
        .btn_clear (btn_clear),
        .value     (value),
        .digits    (digits),
        .full      (full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mval();
        logic [31:0] v = '0;
        foreach (mq[i]) v = (v << 4) | 32'(mq[i]);
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".value"},  value, mval());
        chk({tag, ".digits"}, {28'h0, digits}, 32'(mq.size()));
        chk({tag, ".full"},   {31'h0, full}, {31'h0, mq.size() == 8});
    endtask

    // m = {clear, back, load}; one action per press, clear > load > back.
    task automatic model_apply(input logic [2:0] m, input logic [3:0] nib);
        if (m[2])                        mq.delete();
        else if (m[0]) begin if (mq.size() < 8) mq.push_back(nib); end
        else if (m[1] && mq.size() > 0)  void'(mq.pop_back());
    endtask

    // Clean press: no change through edge LAT-1, update on edge LAT, none on release.
    task automatic press(input logic [2:0] m, input logic [3:0] nib, input string tag);
        @(negedge clock);
        sw = nib;
        {btn_clear, btn_back, btn_load} = m;
        repeat (LAT - 1) @(posedge clock);
        @(negedge clock);
        check_all({tag, ".pre"});
        @(posedge clock);
        @(negedge clock);
        model_apply(m, nib);
        check_all({tag, ".post"});
        {btn_clear, btn_back, btn_load} = 3'b000;
        repeat (LAT + 2) @(negedge clock);
        check_all({tag, ".rel"});
    endtask

    task automatic hold_load(input int n, input logic lvl);
        btn_load = lvl;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; sw = 4'h0;
        btn_load = 1'b0; btn_back = 1'b0; btn_clear = 1'b0;
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b0;

        for (int i = 1; i <= 8; i++) press(3'b001, 4'(i), "fill");
        chk("fill.val", value, 32'h12345678);
        press(3'b001, 4'h9, "ovf");
        press(3'b010, 4'h0, "back1");
        press(3'b010, 4'h0, "back2");
        chk("back.val", value, 32'h00123456);

        // Bouncing load: runs of 3 and 2 samples never reach DB stable cycles.
        @(negedge clock);
        sw = 4'hE;
        repeat (5) begin
            hold_load(3, 1'b1); hold_load(1, 1'b0);
            hold_load(2, 1'b1); hold_load(1, 1'b0);
        end
        hold_load(LAT + 2, 1'b0);
        check_all("bounce");
        press(3'b001, 4'hE, "after_bounce");

        press(3'b100, 4'h0, "clr");
        press(3'b001, 4'h3, "d1");
        press(3'b001, 4'h0, "d2");
        press(3'b001, 4'h7, "d3");
        press(3'b101, 4'hF, "clr_ld");
        press(3'b010, 4'h0, "back_empty");

        // Reset while load is held mid-debounce: one load after release.
        press(3'b001, 4'hA, "a");
        press(3'b001, 4'hB, "b");
        press(3'b001, 4'hC, "c");
        chk("abc.val", value, 32'h00000ABC);
        @(negedge clock);
        sw = 4'h5; btn_load = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mq.delete();
        check_all("rst.now");
        repeat (LAT - 1) @(posedge clock);
        @(negedge clock);
        check_all("rst.pre");
        @(posedge clock);
        @(negedge clock);
        mq.push_back(4'h5);
        check_all("rst.post");
        btn_load = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        check_all("rst.rel");

        for (int i = 0; i < 60; i++)
            press(3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)), "rand");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
